branch_checkpoint_queue: RTL and testbench
==========================================

// Module: branch_checkpoint_queue
// PURPOSE
//  Parametrised circular queue of branch checkpoints (pc, ROB tag, physical-register ready table) for the OoO core.
//  Rename allocates a checkpoint per fu_br instruction. Writebacks keep live snapshots current.
//  The branch FU frees a checkpoint on correct resolve, or restores it on mispredict and squashes it plus every younger checkpoint.
// PARAMETERS
//  NUM_CKPT  4    checkpoint slots; power of two, >=2; ID_W = $clog2(NUM_CKPT)
//  NUM_PREG  128  physical registers = ready-table width; PREG_W = $clog2(NUM_PREG)
//  ROB_W     5    ROB tag width
//  PC_W      32   pc width
// PORTS
//  clk                 in   1         clock, all state on rising edge
//  reset               in   1         synchronous, active-low
//  alloc_valid         in   1         rename requests a checkpoint
//  alloc_ready         out  1         slot available and no mispredict this cycle
//  alloc_pc            in   PC_W      branch pc
//  alloc_rob_tag       in   ROB_W     branch ROB tag
//  alloc_rdy_table     in   NUM_PREG  ready table at rename
//  alloc_id            out  ID_W      slot id taken on alloc_valid&&alloc_ready (= tail)
//  wb_valid            in   1         a physical register became ready
//  wb_preg             in   PREG_W    that register
//  resolve_valid       in   1         branch resolved
//  resolve_id          in   ID_W      its checkpoint id
//  resolve_mispredict  in   1         1 = restore+squash, 0 = free
//  restore_valid       out  1         one-cycle pulse, restore payload valid
//  restore_pc          out  PC_W      restored pc
//  restore_rob_tag     out  ROB_W     restored ROB tag
//  restore_rdy_table   out  NUM_PREG  restored ready table
//  count               out  ID_W+1    slots occupied head..tail
//  empty               out  1         count==0
// BEHAVIOUR
//  - State: entries[NUM_CKPT] {live, pc, rob_tag, rdy}. head/tail pointers ID_W+1 bits; MSB is the wrap bit.
//  - count = tail-head (mod 2^(ID_W+1)). Full when count==NUM_CKPT.
//  - Reset (reset==0 at edge): head=tail=0, all live=0, restore_valid=0, restore_pc/rob_tag/rdy_table=0.
//    Hence count=0, empty=1, alloc_ready=1, alloc_id=0. Reset overrides every other input.
//  - Alloc: alloc_ready = !full && !(resolve_valid&&resolve_mispredict&&entries[resolve_id].live).
//    On fire: entry[tail] is written live=1 with payload; rdy = alloc_rdy_table | onehot(wb_preg) if wb_valid (same-cycle bypass); tail++.
//  - Writeback: if wb_valid, set rdy[wb_preg] in every live entry. Never clears bits.
//  - Correct resolve: if live[resolve_id], clear it. Otherwise ignore (no error).
//  - Head reclaim: each cycle, if count!=0 && !live[head], head++. At most one slot per cycle.
//    A freed slot is reusable only after reclaim, so out-of-order frees stall alloc until older slots free.
//  - Mispredict (resolve_valid&&resolve_mispredict&&live[resolve_id]):
//    * Next cycle: restore_valid=1, payload = entry[resolve_id] including any same-cycle wb bit.
//    * Squash resolve_id and all younger slots (id up to tail-1): live=0, tail = head-relative position of resolve_id (wrap bit recomputed), alloc blocked.
//    * Mispredict on a non-live id is ignored.
//  - restore_valid is high exactly one cycle per accepted mispredict. restore_* hold their last value otherwise.
//  - Latency: alloc_id combinational. Alloc, free, wb and squash take effect at the next edge. Restore output 1 cycle after resolve.
//  - Wrap: pointers wrap modulo 2*NUM_CKPT. Slot index = ptr[ID_W-1:0].
// TESTING
//  1 Reset: drive reset=0 two cycles -> count=0, empty=1, alloc_ready=1, alloc_id=0, restore_valid=0.
//  2 Fill: 4 allocs pc=0x100..0x10C -> ids 0,1,2,3; count=4, alloc_ready=0. A 5th alloc_valid is not accepted.
//  3 Out-of-order free: resolve id1 correct -> count stays 4; resolve id0 -> head passes 0,1 over 2 cycles, count=2, alloc_ready=1.
//  4 Mispredict squash: ids0-3 live; mispredict id1, rob_tag=7, pc=0x104 -> next cycle restore_valid=1, restore_pc=0x104, restore_rob_tag=7; count=1; next alloc_id=1.
//  5 Wb bypass: alloc with table bit 42=0 and wb_valid, wb_preg=42 same cycle; mispredict that id -> restore_rdy_table[42]=1.
//  6 Collision/reset: alloc+mispredict same cycle -> alloc_ready=0, no alloc. Reset mid-stream with 3 live -> all cleared, no restore pulse.

Source files
------------

// File: rtl/branch_checkpoint_queue.sv
// Circular queue of branch checkpoints (pc, ROB tag, ready table) allocated at rename,
// kept current by writebacks, and freed or restored+squashed by the branch unit.
module branch_checkpoint_queue #(
  parameter int NUM_CKPT = 4,
  parameter int NUM_PREG = 128,
  parameter int ROB_W    = 5,
  parameter int PC_W     = 32,
  localparam int ID_W    = $clog2(NUM_CKPT),
  localparam int PREG_W  = $clog2(NUM_PREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [PC_W-1:0]     alloc_pc,
  input  logic [ROB_W-1:0]    alloc_rob_tag,
  input  logic [NUM_PREG-1:0] alloc_rdy_table,
  output logic [ID_W-1:0]     alloc_id,
  input  logic                wb_valid,
  input  logic [PREG_W-1:0]   wb_preg,
  input  logic                resolve_valid,
  input  logic [ID_W-1:0]     resolve_id,
  input  logic                resolve_mispredict,
  output logic                restore_valid,
  output logic [PC_W-1:0]     restore_pc,
  output logic [ROB_W-1:0]    restore_rob_tag,
  output logic [NUM_PREG-1:0] restore_rdy_table,
  output logic [ID_W:0]       count,
  output logic                empty
);

  logic [ID_W:0]         head, tail, cnt;
  logic [ID_W-1:0]       head_idx, tail_idx, rel_res;
  logic [NUM_CKPT-1:0]   live;
  logic [PC_W-1:0]       pc_arr  [NUM_CKPT];
  logic [ROB_W-1:0]      rob_arr [NUM_CKPT];
  logic [NUM_PREG-1:0]   rdy_arr [NUM_CKPT];
  logic [NUM_PREG-1:0]   wb_vec;
  logic                  full, mis, free, reclaim, alloc_fire;

  assign head_idx    = head[ID_W-1:0];
  assign tail_idx    = tail[ID_W-1:0];
  assign cnt         = tail - head;
  assign full        = (cnt == (ID_W+1)'(NUM_CKPT));
  assign mis         = resolve_valid && resolve_mispredict && live[resolve_id];
  assign free        = resolve_valid && !resolve_mispredict;
  assign reclaim     = (cnt != '0) && !live[head_idx];
  assign rel_res     = resolve_id - head_idx;
  assign alloc_ready = !full && !mis;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_id    = tail_idx;
  assign count       = cnt;
  assign empty       = (cnt == '0);
  assign wb_vec      = wb_valid ? (NUM_PREG'(1) << wb_preg) : '0;

  for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_ent
    localparam logic [ID_W-1:0] IDX = ID_W'(gi);
    logic [ID_W-1:0]     rel;
    logic                squash, live_q, hit_alloc;
    logic [PC_W-1:0]     pc_q;
    logic [ROB_W-1:0]    rob_q;
    logic [NUM_PREG-1:0] rdy_q;

    // Age relative to head decides whether this slot is at/younger than the mispredict.
    assign rel       = IDX - head_idx;
    assign squash    = mis && (rel >= rel_res) && ({1'b0, rel} < cnt);
    assign hit_alloc = alloc_fire && (tail_idx == IDX);

    always_ff @(posedge clk) begin
      if (!reset)
        live_q <= 1'b0;
      else if (hit_alloc)
        live_q <= 1'b1;
      else if (squash || (free && resolve_id == IDX))
        live_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
      if (hit_alloc) begin
        pc_q  <= alloc_pc;
        rob_q <= alloc_rob_tag;
        rdy_q <= alloc_rdy_table | wb_vec;
      end else if (live_q) begin
        rdy_q <= rdy_q | wb_vec;
      end
    end

    assign live[gi]    = live_q;
    assign pc_arr[gi]  = pc_q;
    assign rob_arr[gi] = rob_q;
    assign rdy_arr[gi] = rdy_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (reclaim) head <= head + (ID_W+1)'(1);
      // Squash rewinds tail to the mispredicted slot, computed from the pre-reclaim head.
      if (mis)             tail <= head + {1'b0, rel_res};
      else if (alloc_fire) tail <= tail + (ID_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      restore_valid     <= 1'b0;
      restore_pc        <= '0;
      restore_rob_tag   <= '0;
      restore_rdy_table <= '0;
    end else begin
      restore_valid <= mis;
      if (mis) begin
        restore_pc        <= pc_arr[resolve_id];
        restore_rob_tag   <= rob_arr[resolve_id];
        restore_rdy_table <= rdy_arr[resolve_id] | wb_vec;
      end
    end
  end

endmodule

// File: tb/tb_branch_checkpoint_queue.sv
// Directed bench: status checks inline, restore payloads checked by a scoreboard monitor.
module tb_branch_checkpoint_queue;

  logic         clk = 0;
  logic         reset;
  logic         alloc_valid, alloc_ready;
  logic [31:0]  alloc_pc;
  logic [4:0]   alloc_rob_tag;
  logic [127:0] alloc_rdy_table;
  logic [1:0]   alloc_id;
  logic         wb_valid;
  logic [6:0]   wb_preg;
  logic         resolve_valid, resolve_mispredict;
  logic [1:0]   resolve_id;
  logic         restore_valid;
  logic [31:0]  restore_pc;
  logic [4:0]   restore_rob_tag;
  logic [127:0] restore_rdy_table;
  logic [2:0]   count;
  logic         empty;

  typedef struct {
    logic [31:0]  pc;
    logic [4:0]   rob;
    logic [127:0] rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  branch_checkpoint_queue dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
    .alloc_rob_tag(alloc_rob_tag), .alloc_rdy_table(alloc_rdy_table), .alloc_id(alloc_id),
    .wb_valid(wb_valid), .wb_preg(wb_preg),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id), .resolve_mispredict(resolve_mispredict),
    .restore_valid(restore_valid), .restore_pc(restore_pc), .restore_rob_tag(restore_rob_tag),
    .restore_rdy_table(restore_rdy_table), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_restore(input logic [31:0] pc, input logic [4:0] rob, input logic [127:0] rdy);
    exp_t e;
    e.pc = pc; e.rob = rob; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  // Monitor: every restore pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (restore_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL restore_unexpected: got pc %0h expected no pulse", restore_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("restore_pc",  {96'b0, restore_pc},      {96'b0, e.pc});
        chk("restore_rob", {123'b0, restore_rob_tag}, {123'b0, e.rob});
        chk("restore_rdy", restore_rdy_table,         e.rdy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; alloc_valid = 0; alloc_pc = 0; alloc_rob_tag = 0; alloc_rdy_table = 0;
    wb_valid = 0; wb_preg = 0; resolve_valid = 0; resolve_id = 0; resolve_mispredict = 0;

    // Reset
    step(); step();
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_alloc_ready", 128'(alloc_ready), 128'd1);
    chk("rst_alloc_id", 128'(alloc_id), 128'd0);
    chk("rst_restore_valid", 128'(restore_valid), 128'd0);
    reset = 1;

    // Fill
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 1; alloc_pc = 32'h100 + 32'(4*k); alloc_rob_tag = 5'(k);
      #1;
      chk("fill_id", 128'(alloc_id), 128'(k));
      chk("fill_ready", 128'(alloc_ready), 128'd1);
      step();
    end
    chk("full_count", 128'(count), 128'd4);
    chk("full_ready", 128'(alloc_ready), 128'd0);
    alloc_pc = 32'h1FF; step();
    alloc_valid = 0;
    chk("full_reject_count", 128'(count), 128'd4);

    // Out-of-order free
    resolve_valid = 1; resolve_id = 1; resolve_mispredict = 0; step();
    resolve_valid = 0; step();
    chk("ooo_free_count", 128'(count), 128'd4);
    resolve_valid = 1; resolve_id = 0; step();
    resolve_valid = 0;
    step(); step();
    chk("ooo_drain_count", 128'(count), 128'd2);
    chk("ooo_drain_ready", 128'(alloc_ready), 128'd1);

    // Drain the rest: head wraps to slot 0 with wrap bit set
    resolve_valid = 1; resolve_id = 2; step();
    resolve_id = 3; step();
    resolve_valid = 0; step();
    chk("drain_empty", 128'(empty), 128'd1);

    // Mispredict squash
    for (int k = 0; k < 4; k++) begin
      alloc_valid = 1; alloc_pc = 32'h100 + 32'(4*k); alloc_rob_tag = 5'(k + 6); alloc_rdy_table = '0;
      #1;
      chk("refill_id", 128'(alloc_id), 128'(k));
      step();
    end
    alloc_valid = 0;
    resolve_valid = 1; resolve_id = 1; resolve_mispredict = 1;
    exp_restore(32'h104, 5'd7, '0);
    step();
    resolve_valid = 0; resolve_mispredict = 0;
    chk("mis_count", 128'(count), 128'd1);
    chk("mis_alloc_id", 128'(alloc_id), 128'd1);
    step();
    chk("mis_pulse_once", 128'(restore_valid), 128'd0);

    // Wb bypass at alloc (bit 42), then collision of alloc with mispredict plus same-cycle wb
    alloc_valid = 1; alloc_pc = 32'h200; alloc_rob_tag = 5'd11; alloc_rdy_table = 128'h1 << 3;
    wb_valid = 1; wb_preg = 7'd42;
    #1;
    chk("byp_alloc_id", 128'(alloc_id), 128'd1);
    step();
    alloc_pc = 32'h300; alloc_rob_tag = 5'd12; alloc_rdy_table = '0;
    wb_preg = 7'd5;
    resolve_valid = 1; resolve_id = 1; resolve_mispredict = 1;
    exp_restore(32'h200, 5'd11, (128'h1 << 3) | (128'h1 << 42) | (128'h1 << 5));
    #1;
    chk("coll_alloc_ready", 128'(alloc_ready), 128'd0);
    step();
    alloc_valid = 0; wb_valid = 0;
    chk("coll_count", 128'(count), 128'd1);
    chk("coll_alloc_id", 128'(alloc_id), 128'd1);

    // Oldest entry has accumulated both writebacks while live
    resolve_id = 0;
    exp_restore(32'h100, 5'd6, (128'h1 << 42) | (128'h1 << 5));
    step();
    resolve_valid = 0; resolve_mispredict = 0;
    chk("mis0_empty", 128'(empty), 128'd1);

    // Reset mid-stream with 3 live; a concurrent mispredict must not pulse
    for (int k = 0; k < 3; k++) begin
      alloc_valid = 1; alloc_pc = 32'h400 + 32'(4*k); alloc_rob_tag = 5'(k + 20);
      step();
    end
    alloc_valid = 0;
    chk("mid_count", 128'(count), 128'd3);
    reset = 0; resolve_valid = 1; resolve_id = 1; resolve_mispredict = 1;
    step();
    reset = 1; resolve_valid = 0; resolve_mispredict = 0;
    chk("mrst_count", 128'(count), 128'd0);
    chk("mrst_empty", 128'(empty), 128'd1);
    chk("mrst_alloc_id", 128'(alloc_id), 128'd0);
    chk("mrst_restore_valid", 128'(restore_valid), 128'd0);
    chk("mrst_restore_pc", 128'(restore_pc), 128'd0);
    step();
    chk("mrst_no_pulse", 128'(restore_valid), 128'd0);

    chk("sb_outstanding", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
